iter_st_deser: RTL

Serial-to-parallel collector downstream of the `iterSt` single-bit stage. Samples the 1-bit `__out0` stream it produces, one bit per enabled cycle, packs LSB-first into `WIDTH`-bit words, and buffers completed words in a small FIFO with a valid/ready output handshake. Provides the word-wide interface that the bus/host side consumes.

---
 rtl/iter_st_deser_if.sv | 36 +++
 rtl/iter_st_deser.sv | 101 ++++++++++
 2 files changed

// File: rtl/iter_st_deser_if.sv
// Word-side bundle for iter_st_deser: serial input controls plus the FIFO output handshake.
// The out_parity member exists only when ITER_ST_DESER_PARITY_EN is defined.
interface iter_st_deser_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                       __in0;
  logic                       in_en;
  logic                       flush;
  logic [WIDTH-1:0]           out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] fill;
  logic                       overflow;
`ifdef ITER_ST_DESER_PARITY_EN
  logic                       out_parity;
`endif

  // Handshake: a word transfers on a rising clk edge where out_valid & out_ready;
  // out_valid never depends on out_ready, and out_data/out_valid hold while stalled.
  modport slave (
    input  __in0, in_en, flush, out_ready,
    output out_data, out_valid, fill, overflow
`ifdef ITER_ST_DESER_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output __in0, in_en, flush, out_ready,
    input  out_data, out_valid, fill, overflow
`ifdef ITER_ST_DESER_PARITY_EN
    , input  out_parity
`endif
  );
endinterface

// File: rtl/iter_st_deser.sv
// Packs the 1-bit iterSt stream LSB-first into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Optional macro ITER_ST_DESER_PARITY_EN adds a stored even-parity bit per word (bus.out_parity).
module iter_st_deser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  iter_st_deser_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [CW-1:0]    r_cnt;
  // Top bit of the word is taken straight from __in0 at completion, so only WIDTH-1 bits are held.
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [FW-1:0]    r_fill;
  logic             r_overflow;
`ifdef ITER_ST_DESER_PARITY_EN
  logic [DEPTH-1:0] r_par;
`endif

  logic             w_sample;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic [WIDTH-1:0] w_word;

  assign w_sample = bus.in_en & ~bus.flush;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_push   = w_sample & w_last;
  assign w_word   = {bus.__in0, r_acc};
  assign w_full   = (r_fill == FW'(DEPTH));
  assign w_empty  = (r_fill == '0);
  assign w_pop    = ~w_empty & bus.out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts the word.
  assign w_wr     = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (bus.flush) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_sample) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        for (int k = 0; k < WIDTH - 1; k++) begin
          if (r_cnt == CW'(k)) r_acc[k] <= bus.__in0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
`ifdef ITER_ST_DESER_PARITY_EN
      r_par <= '0;
`endif
      r_wr <= '0;
    end else if (w_wr) begin
      r_mem[r_wr] <= w_word;
`ifdef ITER_ST_DESER_PARITY_EN
      r_par[r_wr] <= ^w_word;
`endif
      r_wr <= r_wr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd       <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_wr && !w_pop)      r_fill <= r_fill + FW'(1);
      else if (w_pop && !w_wr) r_fill <= r_fill - FW'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  assign bus.out_data  = r_mem[r_rd];
  assign bus.out_valid = ~w_empty;
  assign bus.fill      = r_fill;
  assign bus.overflow  = r_overflow;
`ifdef ITER_ST_DESER_PARITY_EN
  assign bus.out_parity = r_par[r_rd];
`endif
endmodule
